// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel path.
// Pixels are 15-bit RGB {R[14:10],G[9:5],B[4:0]}, and two of them pack into one
// 30-bit word, first pixel in the low half.
package vga_pkg;

    localparam int RGB_W      = 15;
    localparam int WORD_W     = 2 * RGB_W;
    localparam int FIFO_DEPTH = 16;
    localparam int PTR_W      = 4;
    localparam int CNT_W      = PTR_W + 1;

    // Colour field positions inside an RGB pixel
    localparam int R_MSB = 14;
    localparam int R_LSB = 10;
    localparam int G_MSB = 9;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    typedef logic [RGB_W-1:0]  rgb_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam cnt_t COUNT_FULL = cnt_t'(FIFO_DEPTH);

    // Second pixel goes to the upper half so the first one is scanned out first
    function automatic word_t pack_pair(input rgb_t second, input rgb_t first);
        return {second, first};
    endfunction

    // Select the lower (hi=0) or upper (hi=1) pixel of a packed word
    function automatic rgb_t unpack_half(input word_t w, input logic hi);
        return hi ? w[WORD_W-1:RGB_W] : w[RGB_W-1:0];
    endfunction

endpackage

// File: rtl/dpram_16x30bit.sv
// 16 x 30-bit dual-port distributed RAM.
// Port A writes synchronously and has an asynchronous read; port B is read-only
// with an asynchronous read. No reset on the storage: contents are only
// observed after being written.
module dpram_16x30bit
    import vga_pkg::*;
(
    input  logic  clk,
    input  logic  a_we,
    input  ptr_t  a_addr,
    input  word_t a_wdata,
    output word_t a_rdata,
    input  ptr_t  b_addr,
    output word_t b_rdata
);

    word_t mem [FIFO_DEPTH];

    // Port A write
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
    end

    assign a_rdata = mem[a_addr];
    assign b_rdata = mem[b_addr];

endmodule

// File: rtl/vga_pixel_fifo.sv
// Pixel-pair packing FIFO between PPU pixel output and VGA scan-out.
// Two input pixels are packed into one 30-bit word, buffered in a 16-entry RAM,
// and unpacked through a registered word into a 15-bit pixel stream.
// Optional feature macro: VGA_PIXEL_FIFO_UNDERRUN_EN (sticky underrun flag and
// black output while no pixel is valid).
module vga_pixel_fifo
    import vga_pkg::*;
#(
    parameter int AFULL_LEVEL = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [RGB_W-1:0] in_rgb,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [RGB_W-1:0] out_rgb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] level,
    output logic             almost_full,
    output logic             underrun
);

    localparam cnt_t AFULL_CNT = cnt_t'(AFULL_LEVEL);

    // Write side state
    logic  phase_reg;
    rgb_t  hold_reg;
    ptr_t  wr_ptr_reg;

    // Read side state
    ptr_t  rd_ptr_reg;
    word_t word_reg;
    logic  word_valid_reg;
    logic  half_reg;

    // Stored word count (RAM only, not the output word register)
    cnt_t  count_reg;

    logic  accept;
    logic  wr_en;
    logic  consume;
    logic  load;
    word_t ram_wdata;
    word_t ram_rdata;
    word_t ram_a_rdata_unused;

    // The held pixel can always be taken; only the completing pixel needs room
    assign in_ready  = !phase_reg || (count_reg != COUNT_FULL);
    assign out_valid = word_valid_reg;

    // flush wins over any handshake in the same cycle
    assign accept  = in_valid && in_ready && !flush;
    assign wr_en   = accept && phase_reg;
    assign consume = word_valid_reg && out_ready && !flush;

    // Refill the output word when empty, or as its last pixel leaves, so a
    // continuous stream has no bubble between words
    assign load = !flush && (count_reg != '0) &&
                  (!word_valid_reg || (consume && half_reg));

    assign ram_wdata = pack_pair(in_rgb, hold_reg);

    dpram_16x30bit u_ram (
        .clk     (clk),
        .a_we    (wr_en),
        .a_addr  (wr_ptr_reg),
        .a_wdata (ram_wdata),
        .a_rdata (ram_a_rdata_unused),
        .b_addr  (rd_ptr_reg),
        .b_rdata (ram_rdata)
    );

    // Write side: hold the first pixel of a pair, write the pair on the second
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg  <= 1'b0;
            hold_reg   <= '0;
            wr_ptr_reg <= '0;
        end else if (flush) begin
            phase_reg  <= 1'b0;
            wr_ptr_reg <= '0;
        end else if (accept) begin
            if (!phase_reg) begin
                hold_reg  <= in_rgb;
                phase_reg <= 1'b1;
            end else begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                phase_reg  <= 1'b0;
            end
        end
    end

    // Read side: load words from RAM and step through their two halves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg     <= '0;
            word_reg       <= '0;
            word_valid_reg <= 1'b0;
            half_reg       <= 1'b0;
        end else if (flush) begin
            rd_ptr_reg     <= '0;
            word_valid_reg <= 1'b0;
            half_reg       <= 1'b0;
        end else if (load) begin
            word_reg       <= ram_rdata;
            rd_ptr_reg     <= rd_ptr_reg + 1'b1;
            word_valid_reg <= 1'b1;
            half_reg       <= 1'b0;
        end else if (consume) begin
            if (!half_reg) begin
                half_reg <= 1'b1;
            end else begin
                word_valid_reg <= 1'b0;
            end
        end
    end

    // Word count: a write and a load in the same cycle cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (flush) begin
            count_reg <= '0;
        end else begin
            case ({wr_en, load})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign level       = count_reg;
    assign almost_full = (count_reg >= AFULL_CNT);

`ifdef VGA_PIXEL_FIFO_UNDERRUN_EN
    logic armed_reg;
    logic underrun_reg;

    // Underrun only counts once the stream has started; cleared only by flush/reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_reg    <= 1'b0;
            underrun_reg <= 1'b0;
        end else if (flush) begin
            armed_reg    <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            if (consume) begin
                armed_reg <= 1'b1;
            end
            if (armed_reg && out_ready && !word_valid_reg) begin
                underrun_reg <= 1'b1;
            end
        end
    end

    assign underrun = underrun_reg;
    // Show black rather than stale pixels when nothing is valid
    assign out_rgb  = word_valid_reg ? unpack_half(word_reg, half_reg) : '0;
`else
    assign underrun = 1'b0;
    assign out_rgb  = unpack_half(word_reg, half_reg);
`endif

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Directed bench for vga_pixel_fifo with a pixel scoreboard: every accepted
// pixel is queued and compared, in order, against each pixel taken at the output.
module tb_vga_pixel_fifo;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [14:0] in_rgb;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] out_rgb;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  level;
    logic        almost_full;
    logic        underrun;

    int n_vec = 0;
    int n_err = 0;
    logic [14:0] sb [$];

    vga_pixel_fifo #(.AFULL_LEVEL(12)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_rgb      (in_rgb),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_rgb     (out_rgb),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .almost_full (almost_full),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes against the scoreboard, then advance to edge+1
    task automatic cycle(output bit acc);
        #1;
        acc = in_valid && in_ready && !flush;
        if (flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_extra_output", {17'b0, out_rgb}, 32'hFFFF_FFFF);
                else                chk("sb_pixel", {17'b0, out_rgb}, {17'b0, sb.pop_front()});
            end
            if (acc) sb.push_back(in_rgb);
        end
        @(posedge clk);
        #1;
    endtask

    // Run until every accepted pixel has come out, with a cycle budget
    task automatic drain(input string tag);
        bit a;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0 && !in_valid && !out_valid) begin
                done = 1'b1;
                break;
            end
            cycle(a);
            if (a) in_valid = 1'b0;
        end
        chk({tag, "_drain_done"}, {31'b0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        rst_n = 1'b0; flush = 1'b0; in_rgb = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_level", {27'b0, level}, 32'd0);
        chk("rst_out_rgb", {17'b0, out_rgb}, 32'd0);
        chk("rst_afull", {31'b0, almost_full}, 32'd0);
        chk("rst_underrun", {31'b0, underrun}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
        chk("idle_out_valid", {31'b0, out_valid}, 32'd0);

        // Single pair: latency and ordering
        in_rgb = 15'h7C00; in_valid = 1'b1;
        cycle(acc); chk("pair_acc0", {31'b0, acc}, 32'd1);
        in_rgb = 15'h03E0;
        cycle(acc); chk("pair_acc1", {31'b0, acc}, 32'd1);
        in_valid = 1'b0;
        chk("pair_n1_out_valid", {31'b0, out_valid}, 32'd0);
        chk("pair_n1_level", {27'b0, level}, 32'd1);
        cycle(acc);
        chk("pair_n2_out_valid", {31'b0, out_valid}, 32'd1);
        chk("pair_n2_out_rgb", {17'b0, out_rgb}, 32'h7C00);
        chk("pair_n2_level", {27'b0, level}, 32'd0);
        out_ready = 1'b1;
        drain("pair");
        chk("pair_level_end", {27'b0, level}, 32'd0);

        // Fill with consumer stalled; word 1 sits in the output register, so
        // RAM is full after pixel 34, pixel 35 is held and pixel 36 blocks
        out_ready = 1'b0;
        for (int p = 1; p <= 35; p++) begin
            in_rgb = 15'(p * 97 + 5); in_valid = 1'b1;
            cycle(acc);
            chk("fill_acc", {31'b0, acc}, 32'd1);
            if (p == 24) begin
                chk("fill_level11", {27'b0, level}, 32'd11);
                chk("fill_afull_off", {31'b0, almost_full}, 32'd0);
            end
            if (p == 26) begin
                chk("fill_level12", {27'b0, level}, 32'd12);
                chk("fill_afull_on", {31'b0, almost_full}, 32'd1);
            end
        end
        in_rgb = 15'(36 * 97 + 5);
        chk("full_level", {27'b0, level}, 32'd16);
        chk("full_afull", {31'b0, almost_full}, 32'd1);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        cycle(acc);
        chk("full_blocked", {31'b0, acc}, 32'd0);
        out_ready = 1'b1;
        drain("fill");
        chk("fill_level_end", {27'b0, level}, 32'd0);
        chk("fill_afull_end", {31'b0, almost_full}, 32'd0);

        // Continuous streaming, one pixel per cycle each way
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 640; i++) begin
            in_rgb = 15'($urandom);
            cycle(acc);
            chk("stream_acc", {31'b0, acc}, 32'd1);
            if (i >= 3) begin
                chk("stream_no_bubble", {31'b0, out_valid}, 32'd1);
                chk("stream_level", {31'b0, (level <= 5'd1)}, 32'd1);
            end
        end
        in_valid = 1'b0;
        drain("stream");

        // Flush with 9 words stored and a half pair held
        out_ready = 1'b0;
        for (int p = 1; p <= 21; p++) begin
            in_rgb = 15'(p * 211 + 3); in_valid = 1'b1;
            cycle(acc);
            chk("pre_flush_acc", {31'b0, acc}, 32'd1);
        end
        chk("pre_flush_level", {27'b0, level}, 32'd9);
        flush = 1'b1; in_rgb = 15'h5555; in_valid = 1'b1; out_ready = 1'b1;
        cycle(acc);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_level", {27'b0, level}, 32'd0);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_underrun", {31'b0, underrun}, 32'd0);
        in_rgb = 15'h1234; in_valid = 1'b1;
        cycle(acc); chk("post_flush_acc0", {31'b0, acc}, 32'd1);
        in_rgb = 15'h0ABC;
        cycle(acc); chk("post_flush_acc1", {31'b0, acc}, 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        drain("post_flush");
        cycle(acc);
        cycle(acc);
        chk("idle_out_valid_end", {31'b0, out_valid}, 32'd0);
`ifdef VGA_PIXEL_FIFO_UNDERRUN_EN
        chk("underrun_set", {31'b0, underrun}, 32'd1);
        chk("underrun_black", {17'b0, out_rgb}, 32'd0);
        out_ready = 1'b0;
        cycle(acc);
        chk("underrun_sticky", {31'b0, underrun}, 32'd1);
        flush = 1'b1;
        cycle(acc);
        flush = 1'b0;
        chk("underrun_cleared", {31'b0, underrun}, 32'd0);
`else
        chk("underrun_tied", {31'b0, underrun}, 32'd0);
        chk("stale_word_shown", {17'b0, out_rgb}, 32'h0ABC);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
